demux8_deser: RTL and testbench

- Receiving end of the 8:1 mux serial path. The mux, stepped through select 0..7, emits one bit of an 8-bit word per slot.
- This block generates the slot select, demultiplexes each incoming bit into its slot register, and presents the reassembled word with a one-cycle valid strobe.
- It sits downstream of the mux output Y and drives the mux select lines so both ends stay in lockstep.

---
 rtl/demux8_pkg.sv | 16 +
 rtl/slot_demux.sv | 40 ++++
 rtl/demux8_deser.sv | 112 +++++++++++
 tb/tb_demux8_deser.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux8_pkg.sv
// Shared types and helpers for the 8:1 serial deserializer.
// The select width is derived from the slot count by sel_width().
package demux8_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 8;

    function automatic int sel_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/slot_demux.sv
// Registered 1-to-WIDTH demux: the serial bit lands in the slot addressed by sel.
// clr wipes the whole shadow so an aborted word cannot leak into the next one.
module slot_demux
    import demux8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int SEL_W = sel_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [SEL_W-1:0] sel,
    input  logic             din,
    output logic [WIDTH-1:0] shadow
);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (clr) begin
            shadow_d = '0;
        end else if (we) begin
            shadow_d[sel] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/demux8_deser.sv
// Receive side of the 8:1 mux serial link: drives the mux select, collects one bit
// per slot and presents the finished word with a one-cycle valid strobe.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; sel parked at 0, enable/din ignored
//   ST_SHIFT | capturing din into slot sel on every enabled edge
module demux8_deser
    import demux8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    localparam int SEL_W = sel_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             busy
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] shadow;
    logic             capture;
    logic             last_slot;
    logic             clr_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort || (enable && sel_q == LAST_SLOT)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // abort outranks a same-cycle final capture, so it gates capture entirely
    always_comb begin
        busy       = (state_q == ST_SHIFT);
        capture    = busy && enable && !abort;
        last_slot  = capture && (sel_q == LAST_SLOT);
        clr_shadow = busy && abort;

        sel_d = sel_q;
        if (!busy || abort) begin
            sel_d = '0;
        end else if (capture) begin
            sel_d = sel_q + SEL_W'(1);
        end

        word_d = word_q;
        if (last_slot) begin
            word_d = {din, shadow[WIDTH-2:0]};
        end

        valid_d = last_slot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    slot_demux #(
        .WIDTH (WIDTH)
    ) u_slot_demux (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_shadow),
        .we     (capture),
        .sel    (sel_q),
        .din    (din),
        .shadow (shadow)
    );

    assign sel   = sel_q;
    assign word  = word_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_demux8_deser.sv
// Directed bench for demux8_deser: reset, nominal, stall, abort, collisions, back-to-back.
// Expected words are the mux input patterns; word[k] is the bit sent in slot k.
module tb_demux8_deser;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       start;
    logic       abort;
    logic       din;
    logic [2:0] sel;
    logic [7:0] word;
    logic       valid;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t_valid_a;
    int t_valid_b;

    demux8_deser #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .start  (start),
        .abort  (abort),
        .din    (din),
        .sel    (sel),
        .word   (word),
        .valid  (valid),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] exp_word);
        check({tag, ".sel"},   32'(sel),   32'd0);
        check({tag, ".word"},  32'(word),  32'(exp_word));
        check({tag, ".valid"}, 32'(valid), 32'd0);
        check({tag, ".busy"},  32'(busy),  32'd0);
    endtask

    // Full word transfer; optional stall after slot stall_slot, optional start held in the valid cycle.
    task automatic do_word(input logic [7:0] data, input int stall_slot, input int stall_len,
                           input bit skip_start, input bit chain, input string tag,
                           output int t_valid);
        int t0;
        if (!skip_start) start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s.sel%0d", tag, k), 32'(sel), 32'(k));
            enable = 1'b1;
            din    = data[k];
            tick();
            if (k == stall_slot) begin
                enable = 1'b0;
                din    = ~din;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check($sformatf("%s.stall_sel%0d", tag, s), 32'(sel), 32'(k + 1));
                    check($sformatf("%s.stall_valid%0d", tag, s), 32'(valid), 32'd0);
                end
            end
            if (k < 7) begin
                check($sformatf("%s.valid_early%0d", tag, k), 32'(valid), 32'd0);
            end
        end
        enable = 1'b0;
        start  = chain;
        t_valid = cyc;
        check({tag, ".valid"},   32'(valid), 32'd1);
        check({tag, ".word"},    32'(word),  32'(data));
        check({tag, ".busy_end"}, 32'(busy), 32'd0);
        check({tag, ".sel_wrap"}, 32'(sel),  32'd0);
        check({tag, ".latency"}, 32'(t_valid - t0), 32'(8 + stall_len));
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        enable = 1'b1;
        abort  = 1'b0;
        din    = 1'b1;

        tick();
        check_idle("reset0", 8'h00);
        tick();
        check_idle("reset1", 8'h00);

        rst    = 1'b0;
        start  = 1'b0;
        enable = 1'b0;
        din    = 1'b0;
        tick();
        check_idle("post_reset", 8'h00);

        // enable and din are ignored while idle
        enable = 1'b1;
        din    = 1'b1;
        tick();
        tick();
        check_idle("idle_enable", 8'h00);
        enable = 1'b0;

        do_word(8'h56, -1, 0, 1'b0, 1'b0, "nominal", t_valid_a);
        tick();
        check("nominal.valid_drop", 32'(valid), 32'd0);
        check("nominal.word_hold",  32'(word),  32'h56);

        do_word(8'h56, 3, 3, 1'b0, 1'b0, "stall", t_valid_a);
        tick();
        check("stall.valid_drop", 32'(valid), 32'd0);

        // abort at sel=5: partial 1s must not appear anywhere
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enable = 1'b1;
            din    = 1'b1;
            tick();
        end
        check("abort.sel_before", 32'(sel), 32'd5);
        abort = 1'b1;
        tick();
        abort  = 1'b0;
        enable = 1'b0;
        check_idle("abort", 8'h56);
        tick();
        check_idle("abort_next", 8'h56);

        do_word(8'hFF, -1, 0, 1'b0, 1'b0, "ones", t_valid_a);
        tick();

        // abort coinciding with the final-slot capture
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            enable = 1'b1;
            din    = 1'b0;
            tick();
        end
        check("collide.sel_before", 32'(sel), 32'd7);
        abort  = 1'b1;
        din    = 1'b0;
        tick();
        abort  = 1'b0;
        enable = 1'b0;
        check_idle("collide_abort", 8'hFF);
        tick();
        check_idle("collide_abort_next", 8'hFF);

        // abort in idle blocks a same-cycle start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("idle_abort_start", 8'hFF);

        // start held during the completing cycle is ignored
        start = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            start  = (k == 7);
            enable = 1'b1;
            din    = k[0] ? 1'b0 : 1'b1;
            tick();
        end
        start  = 1'b0;
        enable = 1'b0;
        check("complete_start.valid", 32'(valid), 32'd1);
        check("complete_start.word",  32'(word),  32'h55);
        check("complete_start.busy",  32'(busy),  32'd0);
        tick();
        check_idle("complete_start_next", 8'h55);

        // back-to-back: start re-presented in each valid cycle
        do_word(8'hA5, -1, 0, 1'b0, 1'b1, "b2b_a", t_valid_a);
        do_word(8'h3C, -1, 0, 1'b1, 1'b0, "b2b_b", t_valid_b);
        check("b2b.spacing", 32'(t_valid_b - t_valid_a), 32'd9);
        tick();
        check_idle("b2b_end", 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
